// File: rtl/lcd_bus_scheduler.sv
// HD44780 character-LCD bus controller: power-up delay, fixed init list, then
// round-robin service of two byte requesters with full setup/EN/hold/execute timing.
module lcd_bus_scheduler #(
    parameter int CNT_W   = 20,
    parameter int T_PWRUP = 750000,
    parameter int T_AS    = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       a_valid_i,
    input  logic       a_rs_i,
    input  logic [7:0] a_data_i,
    output logic       a_ready_o,
    input  logic       b_valid_i,
    input  logic       b_rs_i,
    input  logic [7:0] b_data_i,
    output logic       b_ready_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic [7:0] lcd_data_o
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    // A zero timing parameter is treated as a single cycle.
    localparam int P_PWRUP = (T_PWRUP < 1) ? 1 : T_PWRUP;
    localparam int P_AS    = (T_AS    < 1) ? 1 : T_AS;
    localparam int P_EN    = (T_EN    < 1) ? 1 : T_EN;
    localparam int P_HOLD  = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int P_SHORT = (T_SHORT < 1) ? 1 : T_SHORT;
    localparam int P_LONG  = (T_LONG  < 1) ? 1 : T_LONG;

    localparam logic [CNT_W-1:0] LD_PWRUP = P_PWRUP[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LD_AS    = P_AS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LD_EN    = P_EN[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LD_HOLD  = P_HOLD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LD_SHORT = P_SHORT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LD_LONG  = P_LONG[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] INIT_LEN = 3'd5;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             rr_q, rr_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_en_q, lcd_en_d;
    logic             grant_a, grant_b;
    logic             cnt_done;
    logic             long_cmd;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h38;
            3'd2:    init_byte = 8'h0C;
            3'd3:    init_byte = 8'h06;
            3'd4:    init_byte = 8'h01;
            default: init_byte = 8'h00;
        endcase
    endfunction

    // rr_q=0 favours A on a tie; it flips to the other port after every transfer.
    assign grant_a  = a_valid_i && (!b_valid_i || !rr_q);
    assign grant_b  = b_valid_i && (!a_valid_i ||  rr_q);
    assign cnt_done = (cnt_q <= CNT_ONE);
    assign long_cmd = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_PWRUP;
            cnt_q       <= LD_PWRUP;
            idx_q       <= 3'd0;
            init_done_q <= 1'b0;
            rr_q        <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            lcd_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rr_q        <= rr_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            lcd_en_q    <= lcd_en_d;
        end
    end

    // The delay counter is reloaded on every timed-state entry and the state exits when it reads 1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_done ? cnt_q : (cnt_q - CNT_ONE);
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rr_d        = rr_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        case (state_q)
            S_PWRUP: begin
                if (cnt_done) state_d = S_INIT_LOAD;
            end
            S_INIT_LOAD: begin
                state_d    = S_SETUP;
                cnt_d      = LD_AS;
                lcd_rs_d   = 1'b0;
                lcd_data_d = init_byte(idx_q);
                idx_d      = idx_q + 3'd1;
            end
            S_SETUP: begin
                if (cnt_done) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_EN;
                end
            end
            S_PULSE: begin
                if (cnt_done) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    state_d = S_WAIT;
                    cnt_d   = long_cmd ? LD_LONG : LD_SHORT;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q == INIT_LEN) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = S_INIT_LOAD;
                    end
                end
            end
            S_IDLE: begin
                if (grant_a) begin
                    state_d    = S_SETUP;
                    cnt_d      = LD_AS;
                    lcd_rs_d   = a_rs_i;
                    lcd_data_d = a_data_i;
                    rr_d       = 1'b1;
                end else if (grant_b) begin
                    state_d    = S_SETUP;
                    cnt_d      = LD_AS;
                    lcd_rs_d   = b_rs_i;
                    lcd_data_d = b_data_i;
                    rr_d       = 1'b0;
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = LD_PWRUP;
            end
        endcase
    end

    always_comb begin
        a_ready_o = (state_q == S_IDLE) && grant_a;
        b_ready_o = (state_q == S_IDLE) && grant_b;
        lcd_en_d  = (state_d == S_PULSE);
    end

    assign init_done_o = init_done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign lcd_rs_o    = lcd_rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = lcd_en_q;
    assign lcd_data_o  = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler using short simulation timing parameters.
module tb_lcd_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_rs, b_valid, b_rs;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, init_done, busy;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .CNT_W(20), .T_PWRUP(10), .T_AS(1), .T_EN(3),
        .T_HOLD(1), .T_SHORT(5), .T_LONG(20)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_rs_i(a_rs), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_rs_i(b_rs), .b_data_i(b_data), .b_ready_o(b_ready),
        .init_done_o(init_done), .busy_o(busy),
        .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en), .lcd_data_o(lcd_data)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h4B;
        b_valid = 1'b1; b_rs = 1'b0; b_data = 8'h11;
        tick; tick; #1;
        vectors++; if (lcd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en: got %b expected 0", lcd_en); end
        vectors++; if (lcd_rs !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rs: got %b expected 0", lcd_rs); end
        vectors++; if (lcd_rw !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rw: got %b expected 0", lcd_rw); end
        vectors++; if (lcd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", lcd_data); end
        vectors++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
        vectors++; if (init_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
        b_valid = 1'b0;
        tick;
    endtask

    // Called on a negedge with reset asserted; A holds a request for 'K' throughout init.
    task automatic test_init;
        logic [7:0] exp_byte [5];
        int   rise [5];
        int   width [5];
        logic [7:0] seen [5];
        logic seen_rs [5];
        int   pulses, high_len, done_at, ready_bad;
        logic prev_en;
        exp_byte = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        rst = 1'b0;
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h4B; b_valid = 1'b0;
        pulses = 0; high_len = 0; done_at = -1; ready_bad = 0; prev_en = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            tick; #1;
            if (lcd_en && !prev_en && pulses < 5) begin
                rise[pulses] = n; seen[pulses] = lcd_data; seen_rs[pulses] = lcd_rs; high_len = 0;
            end
            if (lcd_en) high_len++;
            if (!lcd_en && prev_en) begin
                if (pulses < 5) width[pulses] = high_len;
                pulses++;
            end
            if (init_done && done_at < 0) done_at = n;
            if ((a_ready || b_ready) && n < 80) ready_bad++;
            prev_en = lcd_en;
        end
        vectors++; if (pulses !== 5) begin miscompares++; $display("[TB] FAIL init_pulse_count: got %0d expected 5", pulses); end
        for (int i = 0; i < 5 && i < pulses; i++) begin
            vectors++; if (rise[i] !== 12 + 11 * i) begin miscompares++; $display("[TB] FAIL init_rise_%0d: got cycle %0d expected %0d", i, rise[i], 12 + 11 * i); end
            vectors++; if (seen[i] !== exp_byte[i] || seen_rs[i] !== 1'b0) begin miscompares++; $display("[TB] FAIL init_byte_%0d: got rs=%b %h expected rs=0 %h", i, seen_rs[i], seen[i], exp_byte[i]); end
            vectors++; if (width[i] !== 3) begin miscompares++; $display("[TB] FAIL init_width_%0d: got %0d expected 3", i, width[i]); end
        end
        vectors++; if (done_at !== 80) begin miscompares++; $display("[TB] FAIL init_done_cycle: got %0d expected 80", done_at); end
        vectors++; if (ready_bad !== 0) begin miscompares++; $display("[TB] FAIL init_ready_early: got %0d cycles expected 0", ready_bad); end
        vectors++; if (a_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL first_grant: got ready=%b busy=%b expected 1 0", a_ready, busy); end
    endtask

    // Continues from test_init: A_READY is high and the next edge transfers 'K'.
    task automatic test_single_write;
        int en_cnt, ready_bad;
        en_cnt = 0; ready_bad = 0;
        for (int n = 1; n <= 10; n++) begin
            tick; #1;
            if (n == 1) begin
                vectors++; if (lcd_rs !== 1'b1 || lcd_data !== 8'h4B || lcd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL write_bus: got rs=%b %h en=%b expected 1 4b 0", lcd_rs, lcd_data, lcd_en); end
            end
            if (lcd_en) begin
                en_cnt++;
                if (n < 2 || n > 4) ready_bad++;
            end
            if (a_ready) ready_bad++;
        end
        vectors++; if (en_cnt !== 3) begin miscompares++; $display("[TB] FAIL write_en_width: got %0d expected 3", en_cnt); end
        vectors++; if (ready_bad !== 0) begin miscompares++; $display("[TB] FAIL write_busy_window: got %0d bad cycles expected 0", ready_bad); end
        tick; #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL write_next_ready: got %b expected 1", a_ready); end
        a_valid = 1'b0; #1;
        vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL withdraw_ready: got %b expected 0", a_ready); end
        tick; #1;
        vectors++; if (busy !== 1'b0 || lcd_data !== 8'h4B) begin miscompares++; $display("[TB] FAIL withdraw_idle: got busy=%b %h expected 0 4b", busy, lcd_data); end
    endtask

    task automatic test_exec_wait;
        logic [7:0] cmd [2];
        int exp_after [2];
        int after;
        logic seen_en, finished, data_ok;
        cmd = '{8'h01, 8'h04};
        exp_after = '{21, 6};
        for (int k = 0; k < 2; k++) begin
            b_valid = 1'b1; b_rs = 1'b0; b_data = cmd[k]; #1;
            vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_ready_%0d: got %b expected 1", k, b_ready); end
            tick; b_valid = 1'b0;
            seen_en = 1'b0; finished = 1'b0; after = 0; data_ok = 1'b1;
            for (int c = 0; c < 60 && !finished; c++) begin
                #1;
                if (lcd_en) begin
                    seen_en = 1'b1;
                    if (lcd_data !== cmd[k] || lcd_rs !== 1'b0) data_ok = 1'b0;
                end else if (seen_en && busy) after++;
                if (seen_en && !lcd_en && !busy) finished = 1'b1;
                else tick;
            end
            vectors++; if (!finished || !data_ok) begin miscompares++; $display("[TB] FAIL wait_run_%0d: got finished=%b data_ok=%b expected 1 1", k, finished, data_ok); end
            vectors++; if (after !== exp_after[k]) begin miscompares++; $display("[TB] FAIL wait_len_%0h: got %0d expected %0d", cmd[k], after, exp_after[k]); end
        end
    endtask

    // Last grant was B, so the pointer favours A for the first tie.
    task automatic test_round_robin;
        logic [7:0] a_bytes [3];
        logic [7:0] b_bytes [3];
        logic [7:0] exp_bus [6];
        logic       exp_is_a [6];
        logic [7:0] bus [6];
        int ai, bi, g, nbus;
        logic pa, pb, prev_en;
        a_bytes = '{8'h41, 8'h42, 8'h43};
        b_bytes = '{8'h61, 8'h62, 8'h63};
        exp_bus = '{8'h41, 8'h61, 8'h42, 8'h62, 8'h43, 8'h63};
        exp_is_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ai = 0; bi = 0; g = 0; nbus = 0; pa = 1'b0; pb = 1'b0; prev_en = lcd_en;
        a_valid = 1'b1; a_rs = 1'b1; a_data = a_bytes[0];
        b_valid = 1'b1; b_rs = 1'b1; b_data = b_bytes[0];
        for (int c = 0; c < 200; c++) begin
            #1;
            if (a_ready || b_ready) begin
                vectors++;
                if (g >= 6 || (a_ready && b_ready) || a_ready !== exp_is_a[g]) begin
                    miscompares++; $display("[TB] FAIL rr_grant_%0d: got a=%b b=%b expected a=%b", g, a_ready, b_ready, (g < 6) ? exp_is_a[g] : 1'b0);
                end
                if (a_ready) pa = 1'b1; else pb = 1'b1;
                g++;
            end
            if (lcd_en && !prev_en) begin
                if (nbus < 6) bus[nbus] = lcd_data;
                nbus++;
            end
            prev_en = lcd_en;
            if (g >= 6 && nbus >= 6 && !busy) break;
            tick;
            if (pa) begin ai++; if (ai < 3) a_data = a_bytes[ai]; else a_valid = 1'b0; pa = 1'b0; end
            if (pb) begin bi++; if (bi < 3) b_data = b_bytes[bi]; else b_valid = 1'b0; pb = 1'b0; end
        end
        vectors++; if (g !== 6 || nbus !== 6) begin miscompares++; $display("[TB] FAIL rr_counts: got grants=%0d bytes=%0d expected 6 6", g, nbus); end
        for (int i = 0; i < 6 && i < nbus; i++) begin
            vectors++; if (bus[i] !== exp_bus[i]) begin miscompares++; $display("[TB] FAIL rr_byte_%0d: got %h expected %h", i, bus[i], exp_bus[i]); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_pulse;
        logic found;
        found = 1'b0;
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h55;
        for (int c = 0; c < 30 && !found; c++) begin
            tick; #1;
            if (lcd_en) found = 1'b1;
        end
        vectors++; if (!found || lcd_data !== 8'h55) begin miscompares++; $display("[TB] FAIL midpulse_en: got found=%b %h expected 1 55", found, lcd_data); end
        a_valid = 1'b0;
        rst = 1'b1; #1;
        vectors++; if (lcd_en !== 1'b0 || init_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midpulse_reset: got en=%b init_done=%b expected 0 0", lcd_en, init_done); end
        vectors++; if (busy !== 1'b1 || lcd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL midpulse_state: got busy=%b %h expected 1 00", busy, lcd_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_init;
        test_single_write;
        test_exec_wait;
        test_round_robin;
        test_reset_mid_pulse;
        test_init;
        a_valid = 1'b0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
